game_soc_hex_display_ctrl: RTL and testbench

GAME_SOC_HEX_DISPLAY_CTRL -- requirements
Module: game_soc_hex_display_ctrl

---
 rtl/game_soc_hex_pkg.sv | 18 +
 rtl/game_soc_hex_seg_decode.sv | 9 +
 rtl/game_soc_hex_display_ctrl.sv | 97 +++++++++
 tb/tb_game_soc_hex_display_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/game_soc_hex_pkg.sv
// game_soc_hex_pkg: register map, segment table and blink divider width for the hex display controller
package game_soc_hex_pkg;
  localparam int BLINK_DIV_W = 24;
  localparam logic [2:0] REG_DATA      = 3'd0;
  localparam logic [2:0] REG_BLANK     = 3'd1;
  localparam logic [2:0] REG_BLINK     = 3'd2;
  localparam logic [2:0] REG_BLINK_DIV = 3'd3;
  localparam logic [2:0] REG_DATA_SET  = 3'd4;
  localparam logic [2:0] REG_DATA_CLR  = 3'd5;
  localparam logic [2:0] REG_STATUS    = 3'd6;
  // active-low, bit order g..a
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/game_soc_hex_seg_decode.sv
// game_soc_hex_seg_decode: one hex nibble to 7 active-low segments
module game_soc_hex_seg_decode
  import game_soc_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/game_soc_hex_display_ctrl.sv
// game_soc_hex_display_ctrl: Avalon-MM hex display with blank/blink masks.
// Define GAME_SOC_HEX_SCAN_EN to build the multiplexed scan engine.
module game_soc_hex_display_ctrl
  import game_soc_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_sel
);
  localparam int DW = 4*NUM_DIGITS;
  logic [DW-1:0] data;
  logic [NUM_DIGITS-1:0] blank, blink;
  logic [BLINK_DIV_W-1:0] blink_div, presc;
  logic phase;
  logic [7*NUM_DIGITS-1:0] segs;
  logic [2:0] idx;
  logic wr;
  logic unused;
  assign wr = chipselect & ~write_n;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [6:0] raw;
    game_soc_hex_seg_decode u_dec (.nibble(data[4*i+:4]), .seg(raw));
    assign segs[7*i+:7] = (blank[i] | (blink[i] & ~phase)) ? 7'h7f : raw;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data      <= '0;
      blank     <= '0;
      blink     <= '0;
      blink_div <= '0;
      presc     <= '0;
      phase     <= 1'b1;
      hex_seg   <= '1;
    end else begin
      if (wr && address == REG_DATA) data <= writedata[DW-1:0];
      else if (wr && address == REG_DATA_SET) data <= data | writedata[DW-1:0];
      else if (wr && address == REG_DATA_CLR) data <= data & ~writedata[DW-1:0];
      if (wr && address == REG_BLANK) blank <= writedata[NUM_DIGITS-1:0];
      if (wr && address == REG_BLINK) blink <= writedata[NUM_DIGITS-1:0];
      if (wr && address == REG_BLINK_DIV) begin
        blink_div <= writedata[BLINK_DIV_W-1:0];
        presc     <= '0;
      end else if (blink_div == '0) begin
        presc <= '0;
        phase <= 1'b1;
      end else if (presc == blink_div) begin
        presc <= '0;
        phase <= ~phase;
      end else presc <= presc + 1'b1;
      hex_seg <= segs;
    end
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA, REG_DATA_SET, REG_DATA_CLR: readdata[DW-1:0] = data;
      REG_BLANK:     readdata[NUM_DIGITS-1:0] = blank;
      REG_BLINK:     readdata[NUM_DIGITS-1:0] = blink;
      REG_BLINK_DIV: readdata[BLINK_DIV_W-1:0] = blink_div;
      REG_STATUS:    readdata = {21'b0, idx, 7'b0, phase};
      default: ;
    endcase
  end
`ifdef GAME_SOC_HEX_SCAN_EN
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV-1);
  logic [SW-1:0] slot;
  assign unused = ^writedata[31:24];
  // guard clocks at both slot ends keep the select lines off while segments change
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot     <= '0;
      idx      <= '0;
      scan_seg <= '1;
      scan_sel <= '1;
    end else begin
      scan_seg <= segs[7*idx+:7];
      scan_sel <= (slot == '0 || slot == SLOT_MAX) ? '1 : ~(NUM_DIGITS'(1) << idx);
      slot     <= (slot == SLOT_MAX) ? '0 : slot + 1'b1;
      if (slot == SLOT_MAX) idx <= (idx == 3'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
    end
`else
  assign unused   = ^{writedata[31:24], SCAN_DIV[0]};
  assign idx      = '0;
  assign scan_seg = '1;
  assign scan_sel = '1;
`endif
endmodule

// File: tb/tb_game_soc_hex_display_ctrl.sv
// tb_game_soc_hex_display_ctrl: randomized register traffic against a behavioural display model
module tb_game_soc_hex_display_ctrl;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 0, reset = 1;
  logic [2:0] address = 0;
  logic chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic [7*N-1:0] hex_seg;
  logic [6:0] scan_seg;
  logic [N-1:0] scan_sel;
  int compared = 0, mismatched = 0;
  logic [15:0] m_data;
  logic [3:0] m_blank, m_blink;
  int m_div, m_cnt, k;
  bit m_phase;
  // active-high lit patterns gfedcba for 0..F
  logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  game_soc_hex_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .hex_seg(hex_seg), .scan_seg(scan_seg), .scan_sel(scan_sel));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig(int i);
    if (m_blank[i] || (m_blink[i] && !m_phase)) return 7'h7f;
    return ~lit[m_data[4*i+:4]];
  endfunction

  function automatic logic [7*N-1:0] all_digits();
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*i+:7] = dig(i);
    return r;
  endfunction

  function automatic int sidx();
`ifdef GAME_SOC_HEX_SCAN_EN
    return (k / D) % N;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] rd(int a);
    logic [2:0] s;
    s = 3'(sidx());
    case (a)
      0, 4, 5: return {16'b0, m_data};
      1: return {28'b0, m_blank};
      2: return {28'b0, m_blink};
      3: return m_div;
      6: return {21'b0, s, 7'b0, m_phase};
      default: return 0;
    endcase
  endfunction

  task automatic step(int a, bit cs, bit wn, logic [31:0] wd);
    logic [7*N-1:0] e_hex;
    logic [6:0] e_seg;
    logic [N-1:0] e_sel;
    address = 3'(a); chipselect = cs; write_n = wn; writedata = wd;
    #1;
    check("readdata", readdata, rd(a));
    e_hex = all_digits();
`ifdef GAME_SOC_HEX_SCAN_EN
    e_seg = dig(sidx());
    e_sel = (k % D == 0 || k % D == D - 1) ? '1 : ~(N'(1) << sidx());
`else
    e_seg = '1;
    e_sel = '1;
`endif
    if (cs && !wn)
      case (a)
        0: m_data = wd[15:0];
        1: m_blank = wd[3:0];
        2: m_blink = wd[3:0];
        4: m_data = m_data | wd[15:0];
        5: m_data = m_data & ~wd[15:0];
        default: ;
      endcase
    if (cs && !wn && a == 3) begin
      m_div = int'(wd[23:0]);
      m_cnt = 0;
    end else if (m_div == 0) begin
      m_cnt = 0;
      m_phase = 1;
    end else if (m_cnt == m_div) begin
      m_cnt = 0;
      m_phase = !m_phase;
    end else m_cnt++;
    k++;
    @(posedge clk);
    #1;
    check("hex_seg", hex_seg, e_hex);
    check("scan_seg", scan_seg, e_seg);
    check("scan_sel", scan_sel, e_sel);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    address = 3'd6; chipselect = 0; write_n = 1;
    #1;
    check("rst_hex", hex_seg, {(7*N){1'b1}});
    check("rst_scan_seg", scan_seg, 7'h7f);
    check("rst_scan_sel", scan_sel, {N{1'b1}});
    check("rst_status", readdata, 32'h1);
    m_data = 0; m_blank = 0; m_blink = 0; m_div = 0; m_cnt = 0; m_phase = 1; k = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    step(0, 1, 0, 32'h1234);
    step(0, 0, 1, 0);
    check("digit0_4", {25'b0, hex_seg[6:0]}, 32'h19);
    check("data_1234", readdata, 32'h1234);
    step(0, 1, 0, 32'h00FF);
    step(4, 1, 0, 32'h0F00);
    step(5, 1, 0, 32'h000F);
    step(0, 0, 1, 0);
    check("set_clr", readdata, 32'h0FF0);
    step(3, 1, 0, 3);
    step(2, 1, 0, 1);
    idle(16);
    step(1, 1, 0, 1);
    idle(10);
    check("blank_dark", {25'b0, hex_seg[6:0]}, 32'h7f);
    step(7, 1, 0, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) step(a, 0, 1, 0);
    step(1, 1, 0, 0);
    step(2, 1, 0, 32'hF);
    step(3, 1, 0, 2);
    for (int i = 0; i < 40 && (sidx() != 2 || k % D != 1); i++) step(6, 0, 1, 0);
    do_reset();
    step(6, 0, 1, 0);
    idle(2 * D * N + 3);
    for (int i = 0; i < 400; i++) begin
      int a;
      logic [31:0] wd;
      a = $urandom_range(0, 7);
      wd = $urandom;
      if (a == 3) wd = $urandom_range(0, 6);
      step(a, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
